// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
// Sequencer in front of the ADC081C021 single-read I2C driver. It triggers
// reads periodically or on request, averages 2^AVG_LOG2 voltage bytes per
// batch, supervises the driver with a done-timeout and raises sticky
// overrun/timeout flags plus a hysteretic high-level alarm.
module adc_sample_scheduler #(
   parameter int unsigned PERIOD   = 50_000,
   parameter int unsigned AVG_LOG2 = 3,
   parameter int unsigned TIMEOUT  = 10_000,
   parameter logic [7:0]  ALARM_HI = 8'd200,
   parameter logic [7:0]  ALARM_LO = 8'd180
) (
   input  logic       sclk,
   input  logic       rst,
   input  logic       enable,
   input  logic       single_req,
   input  logic       clear_err,
   output logic       adc_trigger,
   input  logic       adc_done,
   input  logic [7:0] adc_voltage,
   output logic [7:0] avg_out,
   output logic       avg_valid,
   output logic       busy,
   output logic       alarm,
   output logic       timeout_err,
   output logic       overrun
);

   localparam int unsigned PW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned AW = 8 + AVG_LOG2;
   localparam int unsigned CW = AVG_LOG2 + 1;

   localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] N_LAST = CW'((1 << AVG_LOG2) - 1);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT,
      ACC,
      DONE
   } state_t;

   state_t        state;
   logic [PW-1:0] pcnt;
   logic [TW-1:0] tcnt;
   logic [CW-1:0] cnt;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_sum;
   logic [7:0]    cap;
   logic [7:0]    avg_new;
   logic          tick;
   logic          set_tmo;
   logic          set_ovr;

   assign tick = enable && (pcnt == P_LAST);
   assign busy = (state != IDLE);

   // Sum including the sample just captured, and the average it yields.
   // The average is registered on the ACC->DONE edge so avg_out, alarm and
   // avg_valid all change together while the FSM sits in DONE.
   always_comb begin
      acc_sum = acc + AW'(cap);
      avg_new = 8'(acc_sum >> AVG_LOG2);
      set_tmo = (state == WAIT) && !adc_done && (tcnt == T_LAST);
      set_ovr = tick && (state != IDLE);
   end

   // Free-running period counter, parked at 0 while sampling is disabled.
   always_ff @(posedge sclk) begin
      if (rst || !enable)
         pcnt <= '0;
      else if (pcnt == P_LAST)
         pcnt <= '0;
      else
         pcnt <= pcnt + 1'b1;
   end

   // Batch sequencer with registered outputs; the trigger pulse is raised on
   // entry to TRIG so it is high for exactly the TRIG cycle.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state       <= IDLE;
         adc_trigger <= 1'b0;
         avg_valid   <= 1'b0;
         avg_out     <= '0;
         alarm       <= 1'b0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
         tcnt        <= '0;
         cap         <= '0;
      end else begin
         timeout_err <= set_tmo | (timeout_err & ~clear_err);
         overrun     <= set_ovr | (overrun & ~clear_err);
         adc_trigger <= 1'b0;
         avg_valid   <= 1'b0;
         case (state)
            IDLE: begin
               if (tick || single_req) begin
                  acc         <= '0;
                  cnt         <= '0;
                  adc_trigger <= 1'b1;
                  state       <= TRIG;
               end
            end
            TRIG: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (adc_done) begin
                  cap   <= adc_voltage;
                  state <= ACC;
               end else if (tcnt == T_LAST) begin
                  acc   <= '0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ACC: begin
               acc <= acc_sum;
               cnt <= cnt + 1'b1;
               if (cnt == N_LAST) begin
                  avg_out   <= avg_new;
                  avg_valid <= 1'b1;
                  if (avg_new >= ALARM_HI)
                     alarm <= 1'b1;
                  else if (avg_new <= ALARM_LO)
                     alarm <= 1'b0;
                  state <= DONE;
               end else begin
                  adc_trigger <= 1'b1;
                  state       <= TRIG;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Testbench for adc_sample_scheduler: driver model answering each trigger
// after a programmable delay, scoreboard of expected batch averages.
module tb_adc_sample_scheduler;

   localparam int unsigned PERIOD   = 100;
   localparam int unsigned AVG_LOG2 = 2;
   localparam int unsigned TIMEOUT  = 50;

   logic       sclk = 1'b0;
   logic       rst;
   logic       enable;
   logic       single_req;
   logic       clear_err;
   logic       adc_trigger;
   logic       adc_done = 1'b0;
   logic [7:0] adc_voltage = 8'd0;
   logic [7:0] avg_out;
   logic       avg_valid;
   logic       busy;
   logic       alarm;
   logic       timeout_err;
   logic       overrun;

   adc_sample_scheduler #(
      .PERIOD  (PERIOD),
      .AVG_LOG2(AVG_LOG2),
      .TIMEOUT (TIMEOUT),
      .ALARM_HI(8'd200),
      .ALARM_LO(8'd180)
   ) dut (
      .sclk       (sclk),
      .rst        (rst),
      .enable     (enable),
      .single_req (single_req),
      .clear_err  (clear_err),
      .adc_trigger(adc_trigger),
      .adc_done   (adc_done),
      .adc_voltage(adc_voltage),
      .avg_out    (avg_out),
      .avg_valid  (avg_valid),
      .busy       (busy),
      .alarm      (alarm),
      .timeout_err(timeout_err),
      .overrun    (overrun)
   );

   always #5 sclk = ~sclk;

   int cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Driver model: done pulse mdl_dly cycles after the trigger cycle.
   int          mdl_dly = 10;
   bit          mdl_on  = 1'b1;
   int          rem     = 0;
   byte unsigned vq[$];

   always @(negedge sclk) begin
      adc_done = 1'b0;
      if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            adc_done = 1'b1;
            if (vq.size() > 0) adc_voltage = vq.pop_front();
            else               adc_voltage = 8'hEE;
         end
      end
      if (adc_trigger === 1'b1 && mdl_on) rem = mdl_dly;
   end

   // Monitor and scoreboard.
   int   ntrig  = 0;
   int   nvalid = 0;
   int   trig_cyc[$];
   int   exp_q[$];
   int   e;
   logic mdl_alarm = 1'b0;

   always @(negedge sclk) begin
      if (adc_trigger === 1'b1) begin
         ntrig++;
         trig_cyc.push_back(cyc);
      end
      if (avg_valid === 1'b1) begin
         nvalid++;
         chk("valid_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("avg_out", avg_out, e);
            if (e >= 200)      mdl_alarm = 1'b1;
            else if (e <= 180) mdl_alarm = 1'b0;
            chk("alarm", alarm, mdl_alarm);
         end
      end
   end

   task automatic push_batch(input int a, input int b, input int c, input int d);
      vq.push_back(8'(a));
      vq.push_back(8'(b));
      vq.push_back(8'(c));
      vq.push_back(8'(d));
      exp_q.push_back((a + b + c + d) / 4);
   endtask

   task automatic pulse_req(output int rc);
      @(negedge sclk);
      single_req = 1'b1;
      rc = cyc;
      @(negedge sclk);
      single_req = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge sclk);
      clear_err = 1'b1;
      @(negedge sclk);
      clear_err = 1'b0;
   endtask

   task automatic wait_valids(input string tag, input int target, input int budget);
      int k = 0;
      while (nvalid < target && k < budget) begin
         @(negedge sclk);
         k++;
      end
      chk(tag, nvalid, target);
   endtask

   task automatic check_zero(input string p);
      chk({p, "_avg_out"}, avg_out, 0);
      chk({p, "_avg_valid"}, avg_valid, 0);
      chk({p, "_trigger"}, adc_trigger, 0);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_alarm"}, alarm, 0);
      chk({p, "_timeout_err"}, timeout_err, 0);
      chk({p, "_overrun"}, overrun, 0);
   endtask

   int c0;
   int rc;
   int rc2;
   int nv;

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      single_req = 1'b0;
      clear_err  = 1'b0;
      repeat (3) @(negedge sclk);
      check_zero("rst");
      rst = 1'b0;
      @(negedge sclk);

      // 1: periodic batches
      push_batch(10, 20, 30, 41);
      push_batch(10, 20, 30, 41);
      trig_cyc.delete();
      c0 = cyc;
      enable = 1'b1;
      wait_valids("t1_valids", 2, 400);
      enable = 1'b0;
      chk("t1_ntrig", trig_cyc.size(), 8);
      chk("t1_first_trig", trig_cyc[0], c0 + 100);
      chk("t1_batch_gap", trig_cyc[4] - trig_cyc[0], 100);
      chk("t1_b2b_gap", trig_cyc[1] - trig_cyc[0], 12);
      chk("t1_overrun", overrun, 0);
      repeat (2) @(negedge sclk);
      chk("t1_busy", busy, 0);

      // 2: single requests and alarm hysteresis
      push_batch(200, 200, 200, 203);
      trig_cyc.delete();
      pulse_req(rc);
      repeat (5) @(negedge sclk);
      pulse_req(rc2);
      wait_valids("t2_valids_a", 3, 200);
      chk("t2_req_latency", trig_cyc[0], rc + 1);
      chk("t2_ntrig", trig_cyc.size(), 4);
      chk("t2_alarm_set", alarm, 1);
      chk("t2_overrun", overrun, 0);
      push_batch(190, 190, 190, 190);
      pulse_req(rc);
      wait_valids("t2_valids_b", 4, 200);
      chk("t2_alarm_hold", alarm, 1);
      push_batch(180, 180, 180, 180);
      pulse_req(rc);
      wait_valids("t2_valids_c", 5, 200);
      chk("t2_alarm_clr", alarm, 0);

      // 3: driver never answers
      mdl_on = 1'b0;
      nv = nvalid;
      pulse_req(rc);
      while (timeout_err !== 1'b1 && cyc < rc + 300) @(negedge sclk);
      chk("t3_tmo_cycle", cyc, rc + 1 + 51);
      chk("t3_busy", busy, 0);
      chk("t3_no_valid", nvalid, nv);
      chk("t3_overrun", overrun, 0);
      pulse_clr();
      chk("t3_tmo_clr", timeout_err, 0);
      mdl_on = 1'b1;

      // 4: slow driver, period tick lands inside the batch
      mdl_dly = 40;
      push_batch(50, 60, 70, 80);
      trig_cyc.delete();
      nv = nvalid;
      c0 = cyc;
      enable = 1'b1;
      while (cyc < c0 + 199) @(negedge sclk);
      chk("t4_ovr_before", overrun, 0);
      @(negedge sclk);
      chk("t4_ovr_set", overrun, 1);
      wait_valids("t4_valids", nv + 1, 400);
      enable = 1'b0;
      chk("t4_ntrig", trig_cyc.size(), 4);
      repeat (2) @(negedge sclk);
      pulse_clr();
      chk("t4_ovr_clr", overrun, 0);

      // 5: reset during WAIT, stale done afterwards
      mdl_dly = 10;
      vq.push_back(8'd99);
      nv = nvalid;
      pulse_req(rc);
      repeat (4) @(negedge sclk);
      rst = 1'b1;
      repeat (2) @(negedge sclk);
      check_zero("t5_rst");
      rst = 1'b0;
      repeat (20) @(negedge sclk);
      chk("t5_busy", busy, 0);
      chk("t5_stale_consumed", vq.size(), 0);
      chk("t5_no_valid", nvalid, nv);
      push_batch(4, 8, 12, 16);
      pulse_req(rc);
      wait_valids("t5_valids", nv + 1, 200);

      // 6: done coincides with the last timeout cycle
      mdl_dly = 50;
      push_batch(77, 77, 77, 77);
      nv = nvalid;
      pulse_req(rc);
      wait_valids("t6_valids", nv + 1, 400);
      chk("t6_tmo", timeout_err, 0);

      repeat (5) @(negedge sclk);
      chk("end_exp_q_empty", exp_q.size(), 0);
      chk("end_vq_empty", vq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
